// File: rtl/axi_txn_scheduler_if.sv
// Command-issue interface between the FIFO decoder, the transaction scheduler and the
// AXI4 master's completion side.
//  slave  : scheduler view. It receives requests, drain and completions, and drives
//           grants, start pulses and status.
//  master : decoder/completion view, the mirror image of slave.
// Signals:
//  wr_req/rd_req        command ready, held until the matching grant
//  drain                block new grants
//  wr_done/rd_done      burst completion pulses (B handshake / RLAST beat)
//  wr_err/rd_err        error response, qualified by the matching done
//  wr_gnt/rd_gnt        command accepted
//  wr_trn_en/rd_trn_en  one-cycle burst start pulses
//  wr_outstanding/rd_outstanding  in-flight burst counts
//  idle, err_cnt, cnt_err         status
interface axi_txn_scheduler_if #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned ERR_W = 8
);
  logic             wr_req;
  logic             rd_req;
  logic             drain;
  logic             wr_done;
  logic             wr_err;
  logic             rd_done;
  logic             rd_err;
  logic             wr_gnt;
  logic             rd_gnt;
  logic             wr_trn_en;
  logic             rd_trn_en;
  logic [CNT_W-1:0] wr_outstanding;
  logic [CNT_W-1:0] rd_outstanding;
  logic             idle;
  logic [ERR_W-1:0] err_cnt;
  logic             cnt_err;

  modport slave (
    input  wr_req, rd_req, drain, wr_done, wr_err, rd_done, rd_err,
    output wr_gnt, rd_gnt, wr_trn_en, rd_trn_en, wr_outstanding, rd_outstanding,
           idle, err_cnt, cnt_err
  );

  modport master (
    output wr_req, rd_req, drain, wr_done, wr_err, rd_done, rd_err,
    input  wr_gnt, rd_gnt, wr_trn_en, rd_trn_en, wr_outstanding, rd_outstanding,
           idle, err_cnt, cnt_err
  );
endinterface

// File: rtl/axi_txn_scheduler.sv
// AXI transaction scheduler.
// Arbitrates round-robin between pending write and read commands from the FIFO
// decoder. It turns each grant into a one-cycle burst start pulse and caps the number
// of outstanding bursts per direction at MAX_OUT. It also tracks completions, supports
// drain-to-idle, and counts error responses and counter underflows.
// Ports:
//  ACLK     clock, rising edge
//  ARESETn  asynchronous active-low reset
//  bus      scheduler side (slave modport) of axi_txn_scheduler_if
module axi_txn_scheduler #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_txn_scheduler_if.slave    bus
);

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssueW = 2'd1,
    StIssueR = 2'd2
  } state_e;

  state_e           state_q, state_d;
  // 1: the last grant went to the write side, 0: to the read side.
  logic             rr_last_wr_q, rr_last_wr_d;
  logic [CNT_W-1:0] wr_out_q, wr_out_d;
  logic [CNT_W-1:0] rd_out_q, rd_out_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             cnt_err_q, cnt_err_d;
  logic             idle_q, idle_d;

  logic             wr_elig, rd_elig;
  logic             wr_issue, rd_issue;
  logic             wr_uflow, rd_uflow;
  logic [ERR_W:0]   err_sum;

  assign wr_issue = (state_q == StIssueW);
  assign rd_issue = (state_q == StIssueR);

  assign wr_elig = bus.wr_req && !bus.drain && (wr_out_q < MaxOut);
  assign rd_elig = bus.rd_req && !bus.drain && (rd_out_q < MaxOut);

  // Arbitration FSM. Every issue cycle returns to idle, which limits the rate to one
  // grant every two cycles.
  always_comb begin
    state_d      = state_q;
    rr_last_wr_d = rr_last_wr_q;
    unique case (state_q)
      StIdle: begin
        if (wr_elig && (!rd_elig || !rr_last_wr_q)) begin
          state_d = StIssueW;
        end else if (rd_elig) begin
          state_d = StIssueR;
        end
      end
      StIssueW: begin
        state_d      = StIdle;
        rr_last_wr_d = 1'b1;
      end
      StIssueR: begin
        state_d      = StIdle;
        rr_last_wr_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outstanding counters. An issue and a done in the same cycle cancel out. A done
  // with no burst in flight is an underflow: the count stays at zero.
  always_comb begin
    wr_out_d = wr_out_q;
    wr_uflow = 1'b0;
    unique case ({wr_issue, bus.wr_done})
      2'b10: wr_out_d = wr_out_q + CNT_W'(1);
      2'b01: begin
        if (wr_out_q == '0) begin
          wr_uflow = 1'b1;
        end else begin
          wr_out_d = wr_out_q - CNT_W'(1);
        end
      end
      default: wr_out_d = wr_out_q;
    endcase
  end

  always_comb begin
    rd_out_d = rd_out_q;
    rd_uflow = 1'b0;
    unique case ({rd_issue, bus.rd_done})
      2'b10: rd_out_d = rd_out_q + CNT_W'(1);
      2'b01: begin
        if (rd_out_q == '0) begin
          rd_uflow = 1'b1;
        end else begin
          rd_out_d = rd_out_q - CNT_W'(1);
        end
      end
      default: rd_out_d = rd_out_q;
    endcase
  end

  // The error counter can gain 0, 1 or 2 per cycle. It is summed one bit wider so
  // that a carry out means saturation.
  always_comb begin
    err_sum = {1'b0, err_cnt_q}
            + {{ERR_W{1'b0}}, bus.wr_done & bus.wr_err}
            + {{ERR_W{1'b0}}, bus.rd_done & bus.rd_err};
    err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  assign cnt_err_d = cnt_err_q | wr_uflow | rd_uflow;

  // The idle state has no grant active, so idle only needs the state and the counters.
  assign idle_d = (state_q == StIdle) && (wr_out_q == '0) && (rd_out_q == '0);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      rr_last_wr_q <= 1'b0;
      wr_out_q     <= '0;
      rd_out_q     <= '0;
      err_cnt_q    <= '0;
      cnt_err_q    <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      rr_last_wr_q <= rr_last_wr_d;
      wr_out_q     <= wr_out_d;
      rd_out_q     <= rd_out_d;
      err_cnt_q    <= err_cnt_d;
      cnt_err_q    <= cnt_err_d;
      idle_q       <= idle_d;
    end
  end

  assign bus.wr_gnt         = wr_issue;
  assign bus.rd_gnt         = rd_issue;
  assign bus.wr_trn_en      = wr_issue;
  assign bus.rd_trn_en      = rd_issue;
  assign bus.wr_outstanding = wr_out_q;
  assign bus.rd_outstanding = rd_out_q;
  assign bus.idle           = idle_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.cnt_err        = cnt_err_q;

  a_one_grant: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !(bus.wr_gnt && bus.rd_gnt));
  a_wr_cap: assert property (@(posedge ACLK) disable iff (!ARESETn) wr_out_q <= MaxOut);
  a_rd_cap: assert property (@(posedge ACLK) disable iff (!ARESETn) rd_out_q <= MaxOut);

endmodule

// File: tb/tb_axi_txn_scheduler.sv
module tb_axi_txn_scheduler;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ERR_W   = 8;

  logic ACLK = 1'b0;
  logic ARESETn;
  int   checks = 0;
  int   errors = 0;

  always #5 ACLK = ~ACLK;

  axi_txn_scheduler_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  axi_txn_scheduler #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus.slave)
  );

  // Reference model: a grant follows one cycle after a cycle with no grant in which
  // the direction was eligible. Counters are issued minus completed, floored at 0.
  int m_wr, m_rd, m_err;
  bit m_gw, m_gr, m_last_w, m_cnt_err, m_idle;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_err = 0;
    m_gw = 0; m_gr = 0; m_last_w = 0; m_cnt_err = 0; m_idle = 1;
  endtask

  // Advance the model across one clock edge, using the inputs of the closing cycle.
  task automatic model_edge();
    int nw, nr;
    bit ew, er, gw, gr;
    nw = m_wr + int'(m_gw) - int'(bus.wr_done);
    nr = m_rd + int'(m_gr) - int'(bus.rd_done);
    if (nw < 0) begin nw = 0; m_cnt_err = 1; end
    if (nr < 0) begin nr = 0; m_cnt_err = 1; end
    m_err = m_err + int'(bus.wr_done & bus.wr_err) + int'(bus.rd_done & bus.rd_err);
    if (m_err > 255) m_err = 255;
    m_idle = !m_gw && !m_gr && m_wr == 0 && m_rd == 0;
    gw = 0; gr = 0;
    if (!m_gw && !m_gr) begin
      ew = bus.wr_req && !bus.drain && m_wr < int'(MAX_OUT);
      er = bus.rd_req && !bus.drain && m_rd < int'(MAX_OUT);
      gw = ew && (!er || !m_last_w);
      gr = er && !gw;
    end
    if (gw) m_last_w = 1;
    if (gr) m_last_w = 0;
    m_gw = gw; m_gr = gr; m_wr = nw; m_rd = nr;
  endtask

  task automatic clear_inputs();
    bus.wr_req = 0; bus.rd_req = 0; bus.drain = 0;
    bus.wr_done = 0; bus.wr_err = 0; bus.rd_done = 0; bus.rd_err = 0;
  endtask

  // Step to just after the next rising edge, where inputs for the new cycle are driven.
  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  // Move to the middle of the current cycle, where outputs are sampled.
  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETn = 0;
    clear_inputs();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
  endtask

  task automatic test_reset();
    ARESETn = 0;
    clear_inputs();
    repeat (2) @(posedge ACLK);
    mid();
    if ({bus.wr_gnt, bus.rd_gnt, bus.wr_trn_en, bus.rd_trn_en} !== 4'b0) begin
      errors++; $display("FAIL reset_gnt got %b want 0000",
                         {bus.wr_gnt, bus.rd_gnt, bus.wr_trn_en, bus.rd_trn_en});
    end
    checks++;
    if (bus.wr_outstanding !== 3'd0 || bus.rd_outstanding !== 3'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0",
                         bus.wr_outstanding, bus.rd_outstanding);
    end
    checks++;
    if (bus.idle !== 1'b1 || bus.err_cnt !== 8'd0 || bus.cnt_err !== 1'b0) begin
      errors++; $display("FAIL reset_status got idle=%b err=%0d cerr=%b want 1/0/0",
                         bus.idle, bus.err_cnt, bus.cnt_err);
    end
    checks++;
    #1 ARESETn = 1;
  endtask

  task automatic test_single_write();
    do_reset();
    bus.wr_req = 1;
    mid();
    if (bus.wr_gnt !== 1'b0) begin
      errors++; $display("FAIL single_c0_gnt got %b want 0", bus.wr_gnt);
    end
    checks++;
    cyc(); mid();
    if ({bus.wr_gnt, bus.wr_trn_en, bus.rd_gnt, bus.rd_trn_en} !== 4'b1100) begin
      errors++; $display("FAIL single_c1_gnt got %b want 1100",
                         {bus.wr_gnt, bus.wr_trn_en, bus.rd_gnt, bus.rd_trn_en});
    end
    checks++;
    cyc(); bus.wr_req = 0; mid();
    if ({bus.wr_gnt, bus.wr_trn_en} !== 2'b00 || bus.wr_outstanding !== 3'd1) begin
      errors++; $display("FAIL single_c2 got gnt=%b cnt=%0d want 00/1",
                         {bus.wr_gnt, bus.wr_trn_en}, bus.wr_outstanding);
    end
    checks++;
    cyc(); mid();
    if (bus.wr_gnt !== 1'b0 || bus.idle !== 1'b0) begin
      errors++; $display("FAIL single_c3 got gnt=%b idle=%b want 0/0", bus.wr_gnt, bus.idle);
    end
    checks++;
  endtask

  // Both requests held with no completions: alternating grants until both caps hit,
  // then a single write completion frees one slot.
  task automatic test_round_robin_and_cap();
    bit ew, er;
    do_reset();
    bus.wr_req = 1; bus.rd_req = 1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) cyc();
      mid();
      ew = (k <= 15) && (k % 4 == 1);
      er = (k <= 15) && (k % 4 == 3);
      if (bus.wr_gnt !== ew || bus.rd_gnt !== er) begin
        errors++; $display("FAIL rr_cycle%0d got w=%b r=%b want w=%b r=%b",
                           k, bus.wr_gnt, bus.rd_gnt, ew, er);
      end
      checks++;
    end
    if (bus.wr_outstanding !== 3'd4 || bus.rd_outstanding !== 3'd4) begin
      errors++; $display("FAIL rr_cap got %0d/%0d want 4/4",
                         bus.wr_outstanding, bus.rd_outstanding);
    end
    checks++;
    cyc(); bus.wr_done = 1; mid();
    if (bus.wr_outstanding !== 3'd4 || bus.wr_gnt !== 1'b0) begin
      errors++; $display("FAIL blk_done_c0 got cnt=%0d gnt=%b want 4/0",
                         bus.wr_outstanding, bus.wr_gnt);
    end
    checks++;
    cyc(); bus.wr_done = 0; mid();
    if (bus.wr_outstanding !== 3'd3 || bus.wr_gnt !== 1'b0) begin
      errors++; $display("FAIL blk_done_c1 got cnt=%0d gnt=%b want 3/0",
                         bus.wr_outstanding, bus.wr_gnt);
    end
    checks++;
    cyc(); mid();
    if (bus.wr_gnt !== 1'b1 || bus.rd_gnt !== 1'b0) begin
      errors++; $display("FAIL blk_done_c2 got w=%b r=%b want 1/0", bus.wr_gnt, bus.rd_gnt);
    end
    checks++;
    cyc(); mid();
    if (bus.wr_outstanding !== 3'd4 || bus.wr_gnt !== 1'b0) begin
      errors++; $display("FAIL blk_done_c3 got cnt=%0d gnt=%b want 4/0",
                         bus.wr_outstanding, bus.wr_gnt);
    end
    checks++;
    clear_inputs();
  endtask

  task automatic test_drain();
    do_reset();
    bus.drain = 1; bus.wr_req = 1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) cyc();
      mid();
      if (bus.wr_gnt !== 1'b0 || bus.idle !== 1'b1) begin
        errors++; $display("FAIL drain_hold%0d got gnt=%b idle=%b want 0/1",
                           k, bus.wr_gnt, bus.idle);
      end
      checks++;
    end
    cyc(); bus.drain = 0; mid();
    if (bus.wr_gnt !== 1'b0) begin
      errors++; $display("FAIL drain_release got gnt=%b want 0", bus.wr_gnt);
    end
    checks++;
    // Drain raised during the issue cycle must not cancel that issue.
    cyc(); bus.drain = 1; mid();
    if (bus.wr_gnt !== 1'b1 || bus.wr_trn_en !== 1'b1) begin
      errors++; $display("FAIL drain_in_issue got gnt=%b trn=%b want 1/1",
                         bus.wr_gnt, bus.wr_trn_en);
    end
    checks++;
    cyc(); bus.wr_req = 0; mid();
    if (bus.wr_outstanding !== 3'd1) begin
      errors++; $display("FAIL drain_issue_cnt got %0d want 1", bus.wr_outstanding);
    end
    checks++;
    clear_inputs();
  endtask

  task automatic test_underflow();
    do_reset();
    bus.wr_done = 1;
    mid();
    if (bus.cnt_err !== 1'b0) begin
      errors++; $display("FAIL uflow_c0 got %b want 0", bus.cnt_err);
    end
    checks++;
    cyc(); bus.wr_done = 0; mid();
    if (bus.cnt_err !== 1'b1 || bus.wr_outstanding !== 3'd0) begin
      errors++; $display("FAIL uflow_c1 got cerr=%b cnt=%0d want 1/0",
                         bus.cnt_err, bus.wr_outstanding);
    end
    checks++;
    repeat (4) cyc();
    mid();
    if (bus.cnt_err !== 1'b1) begin
      errors++; $display("FAIL uflow_sticky got %b want 1", bus.cnt_err);
    end
    checks++;
  endtask

  task automatic test_err_count();
    do_reset();
    bus.wr_done = 1; bus.wr_err = 1; bus.rd_done = 1; bus.rd_err = 1;
    cyc(); mid();
    if (bus.err_cnt !== 8'd2) begin
      errors++; $display("FAIL err_double got %0d want 2", bus.err_cnt);
    end
    checks++;
    repeat (126) cyc();
    mid();
    if (bus.err_cnt !== 8'd254) begin
      errors++; $display("FAIL err_254 got %0d want 254", bus.err_cnt);
    end
    checks++;
    cyc(); bus.rd_done = 0; bus.rd_err = 0; mid();
    if (bus.err_cnt !== 8'd255) begin
      errors++; $display("FAIL err_sat got %0d want 255", bus.err_cnt);
    end
    checks++;
    cyc(); mid();
    if (bus.err_cnt !== 8'd255) begin
      errors++; $display("FAIL err_sat_hold got %0d want 255", bus.err_cnt);
    end
    checks++;
    clear_inputs();
  endtask

  // Reset asserted mid-operation clears everything at once, without waiting for a clock.
  task automatic test_reset_mid();
    do_reset();
    bus.wr_req = 1; bus.rd_req = 1;
    repeat (6) cyc();
    bus.wr_done = 1; bus.wr_err = 1;
    cyc(); bus.wr_done = 0; bus.wr_err = 0;
    mid();
    #1 ARESETn = 0;
    #1;
    if (bus.wr_outstanding !== 3'd0 || bus.rd_outstanding !== 3'd0 ||
        bus.wr_gnt !== 1'b0 || bus.rd_gnt !== 1'b0) begin
      errors++; $display("FAIL rstmid_cnt got %0d/%0d gnt=%b%b want 0/0 00",
                         bus.wr_outstanding, bus.rd_outstanding, bus.wr_gnt, bus.rd_gnt);
    end
    checks++;
    if (bus.idle !== 1'b1 || bus.err_cnt !== 8'd0 || bus.cnt_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_status got idle=%b err=%0d cerr=%b want 1/0/0",
                         bus.idle, bus.err_cnt, bus.cnt_err);
    end
    checks++;
    clear_inputs();
    @(posedge ACLK); #1 ARESETn = 1;
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    bit saw_w, saw_r;
    do_reset();
    model_reset();
    saw_w = 0; saw_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc();
      if (bus.wr_req && saw_w) bus.wr_req = $urandom_range(0, 1) == 1;
      else if (!bus.wr_req)    bus.wr_req = $urandom_range(0, 1) == 1;
      if (bus.rd_req && saw_r) bus.rd_req = $urandom_range(0, 1) == 1;
      else if (!bus.rd_req)    bus.rd_req = $urandom_range(0, 1) == 1;
      bus.drain   = $urandom_range(0, 7) == 0;
      bus.wr_done = (m_wr > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      bus.rd_done = (m_rd > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      bus.wr_err  = $urandom_range(0, 3) == 0;
      bus.rd_err  = $urandom_range(0, 3) == 0;
      mid();
      got = {bus.wr_gnt, bus.rd_gnt, bus.wr_trn_en, bus.rd_trn_en, bus.wr_outstanding,
             bus.rd_outstanding, bus.idle, bus.err_cnt, bus.cnt_err};
      exp = {m_gw, m_gr, m_gw, m_gr, 3'(m_wr), 3'(m_rd), m_idle, 8'(m_err), m_cnt_err};
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle%0d got %h want %h", c, got, exp);
      end
      checks++;
      saw_w = bus.wr_gnt; saw_r = bus.rd_gnt;
      model_edge();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin_and_cap();
    test_drain();
    test_underflow();
    test_err_count();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
